// File: rtl/hazard_scoreboard.sv
// In-order issue scoreboard: per-register writeback countdowns gate issue on RAW hazards,
// a small FSM blocks issue for the control shadow and latches halt.
module hazard_scoreboard #(
    parameter int                INST_W     = 16,
    parameter int                NREG       = 8,
    parameter int                RA_W       = 3,
    parameter int                WB_LAT     = 4,
    parameter int                BR_BUBBLES = 2,
    parameter logic [INST_W-1:0] NOP_INST   = 16'h0800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INST_W-1:0] inst_in,
    input  logic              inst_valid,
    input  logic              src1_used,
    input  logic              src2_used,
    input  logic [RA_W-1:0]   src1,
    input  logic [RA_W-1:0]   src2,
    input  logic              dst_wr,
    input  logic [RA_W-1:0]   dst,
    input  logic              is_ctrl,
    input  logic              is_halt,
    input  logic              ctrl_resolved,
    output logic              issue,
    output logic              stall,
    output logic [INST_W-1:0] inst_out,
    output logic              halted,
    output logic [NREG-1:0]   pend_mask,
    output logic [15:0]       stall_cycles
);

    localparam int CNT_W = $clog2(WB_LAT + 1);
    localparam int NADDR = 1 << RA_W;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_SHADOW,
        ST_HALTED
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [2:0]        r_shadow;
    logic [2:0]        w_shadow_next;
    logic [CNT_W-1:0]  r_cnt [NREG];
    logic [INST_W-1:0] r_inst_out;
    logic [15:0]       r_stall_cycles;

    logic [NREG-1:0]   w_pend;
    logic [NADDR-1:0]  w_pend_addr;
    logic              w_hazard;
    logic              w_issue;
    logic              w_stall;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_cnt
            localparam logic [RA_W-1:0] ADDR = RA_W'(gi);

            assign w_pend[gi] = (r_cnt[gi] != '0);

            // Reload on issue beats decrement, so a WAW simply restarts the countdown.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt[gi] <= '0;
                end else if (w_issue && dst_wr && (dst == ADDR)) begin
                    r_cnt[gi] <= CNT_W'(WB_LAT);
                end else if (r_cnt[gi] != '0) begin
                    r_cnt[gi] <= r_cnt[gi] - 1'b1;
                end
            end
        end

        // Addresses beyond the register file read as never pending.
        for (genvar gi = 0; gi < NADDR; gi++) begin : g_addr
            if (gi < NREG) begin : g_real
                assign w_pend_addr[gi] = w_pend[gi];
            end else begin : g_none
                assign w_pend_addr[gi] = 1'b0;
            end
        end
    endgenerate

    assign w_hazard = (src1_used && w_pend_addr[src1]) || (src2_used && w_pend_addr[src2]);
    assign w_issue  = inst_valid && !rst && (r_state == ST_RUN) && !w_hazard;
    assign w_stall  = inst_valid && !w_issue;

    always_comb begin
        w_state_next  = r_state;
        w_shadow_next = r_shadow;
        unique case (r_state)
            ST_RUN: begin
                if (w_issue && is_halt) begin
                    w_state_next = ST_HALTED;
                end else if (w_issue && is_ctrl && (BR_BUBBLES > 0)) begin
                    w_state_next  = ST_SHADOW;
                    w_shadow_next = 3'(BR_BUBBLES);
                end
            end
            ST_SHADOW: begin
                if ((r_shadow == 3'd1) || ctrl_resolved) begin
                    w_state_next  = ST_RUN;
                    w_shadow_next = 3'd0;
                end else begin
                    w_shadow_next = r_shadow - 3'd1;
                end
            end
            ST_HALTED: begin
                w_state_next = ST_HALTED;
            end
            default: begin
                w_state_next  = ST_RUN;
                w_shadow_next = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_RUN;
            r_shadow       <= 3'd0;
            r_inst_out     <= NOP_INST;
            r_stall_cycles <= 16'd0;
        end else begin
            r_state    <= w_state_next;
            r_shadow   <= w_shadow_next;
            r_inst_out <= w_issue ? inst_in : NOP_INST;
            if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
        end
    end

    assign issue        = w_issue;
    assign stall        = w_stall;
    assign inst_out     = r_inst_out;
    assign halted       = (r_state == ST_HALTED);
    assign pend_mask    = w_pend;
    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard at WB_LAT=4, BR_BUBBLES=2: RAW stall, WAW reload,
// control shadow, early resolve, halt, and reset recovery.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] inst_in;
    logic        inst_valid;
    logic        src1_used;
    logic        src2_used;
    logic [2:0]  src1;
    logic [2:0]  src2;
    logic        dst_wr;
    logic [2:0]  dst;
    logic        is_ctrl;
    logic        is_halt;
    logic        ctrl_resolved;
    logic        issue;
    logic        stall;
    logic [15:0] inst_out;
    logic        halted;
    logic [7:0]  pend_mask;
    logic [15:0] stall_cycles;

    int passed = 0;
    int total  = 0;

    localparam logic [15:0] NOP = 16'h0800;

    hazard_scoreboard #(
        .INST_W(16), .NREG(8), .RA_W(3), .WB_LAT(4), .BR_BUBBLES(2), .NOP_INST(16'h0800)
    ) dut (
        .clk(clk), .rst(rst), .inst_in(inst_in), .inst_valid(inst_valid),
        .src1_used(src1_used), .src2_used(src2_used), .src1(src1), .src2(src2),
        .dst_wr(dst_wr), .dst(dst), .is_ctrl(is_ctrl), .is_halt(is_halt),
        .ctrl_resolved(ctrl_resolved), .issue(issue), .stall(stall),
        .inst_out(inst_out), .halted(halted), .pend_mask(pend_mask),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic idle();
        inst_in = NOP; inst_valid = 0; src1_used = 0; src2_used = 0;
        src1 = 0; src2 = 0; dst_wr = 0; dst = 0; is_ctrl = 0; is_halt = 0;
        ctrl_resolved = 0;
    endtask

    // Advance to just after the next rising edge; inputs are then changed mid-cycle.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        idle();
        rst = 1;
        nxt();
        inst_valid = 1; inst_in = 16'hAAAA; settle();
        check("issue_in_reset", issue, 0);
        nxt();
        rst = 0; idle(); settle();
        check("rst_pend", pend_mask, 8'h00);
        check("rst_halted", halted, 0);
        check("rst_inst_out", inst_out, NOP);
        check("rst_stall_cnt", stall_cycles, 0);

        // RAW on r3: stall cycles 1-4, issue cycle 5
        nxt();
        inst_valid = 1; inst_in = 16'h1003; dst_wr = 1; dst = 3; settle();
        check("raw_c0_issue", issue, 1);
        nxt();
        idle(); inst_valid = 1; inst_in = 16'h2013; src1_used = 1; src1 = 3; settle();
        check("raw_inst_out", inst_out, 16'h1003);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("raw_c%0d_stall", k), stall, 1);
            check($sformatf("raw_c%0d_pend", k), pend_mask, 8'h08);
            nxt();
        end
        check("raw_c5_issue", issue, 1);
        check("raw_c5_pend", pend_mask, 8'h00);
        nxt();
        idle(); settle();
        check("raw_stall_cnt", stall_cycles, 4);
        check("raw_inst_out2", inst_out, 16'h2013);

        // WAW reload: r3 pending, reader of r5 writing r3 issues and restarts r3 at 4
        nxt();
        inst_valid = 1; inst_in = 16'h1103; dst_wr = 1; dst = 3; settle();
        nxt();
        idle(); inst_valid = 1; inst_in = 16'h1153; src1_used = 1; src1 = 5;
        dst_wr = 1; dst = 3; settle();
        check("waw_issue", issue, 1);
        check("waw_pend", pend_mask, 8'h08);
        nxt(); idle(); settle();
        nxt(); nxt(); nxt(); settle();
        check("waw_reload_c5", pend_mask, 8'h08);
        nxt(); settle();
        check("waw_reload_c6", pend_mask, 8'h00);

        // Own destination as source while not pending: no self-hazard
        inst_valid = 1; inst_in = 16'h1666; src1_used = 1; src1 = 6; dst_wr = 1; dst = 6; settle();
        check("self_dst_issue", issue, 1);
        nxt(); idle(); settle();
        check("self_dst_pend", pend_mask, 8'h40);
        nxt(); nxt(); nxt(); nxt(); settle();

        // Control shadow: stall cycles 1-2, issue cycle 3
        inst_valid = 1; inst_in = 16'h3000; is_ctrl = 1; settle();
        check("br_c0_issue", issue, 1);
        nxt();
        idle(); inst_valid = 1; inst_in = 16'h4000; settle();
        check("br_c1_stall", stall, 1);
        check("br_c1_inst_out", inst_out, 16'h3000);
        nxt();
        check("br_c2_stall", stall, 1);
        check("br_c2_inst_out", inst_out, NOP);
        nxt();
        check("br_c3_issue", issue, 1);
        check("br_c3_inst_out", inst_out, NOP);
        nxt(); idle(); settle();
        check("br_inst_out", inst_out, 16'h4000);
        check("br_stall_cnt", stall_cycles, 6);

        // Early resolve: issue in cycle 2
        nxt();
        inst_valid = 1; inst_in = 16'h3100; is_ctrl = 1; settle();
        nxt();
        idle(); inst_valid = 1; inst_in = 16'h4100; ctrl_resolved = 1; settle();
        check("res_c1_stall", stall, 1);
        nxt();
        ctrl_resolved = 0; settle();
        check("res_c2_issue", issue, 1);
        nxt(); idle(); settle();
        check("res_stall_cnt", stall_cycles, 7);

        // Halt (with is_ctrl also set; halt wins) writing r1; counters keep running
        nxt();
        inst_valid = 1; inst_in = 16'h5001; is_halt = 1; is_ctrl = 1; dst_wr = 1; dst = 1; settle();
        check("halt_c0_issue", issue, 1);
        for (int c = 1; c <= 9; c++) begin
            nxt();
            idle(); inst_valid = 1; inst_in = 16'h6000; settle();
            if (c == 1) check("halt_c1_halted", halted, 1);
            if (c == 4) check("halt_c4_pend", pend_mask, 8'h02);
            if (c == 5) check("halt_c5_pend", pend_mask, 8'h00);
            if (c == 9) check("halt_c9_stall", stall, 1);
            check($sformatf("halt_c%0d_issue", c), issue, 0);
        end
        nxt();
        rst = 1; settle();
        check("halt_c10_rst_issue", issue, 0);
        nxt();
        rst = 0; settle();
        check("halt_c11_halted", halted, 0);
        check("halt_c11_issue", issue, 1);

        // Reset while r3 pending and a dependent instruction stalls
        nxt();
        idle(); inst_valid = 1; inst_in = 16'h1003; dst_wr = 1; dst = 3; settle();
        nxt();
        idle(); inst_valid = 1; inst_in = 16'h2013; src1_used = 1; src1 = 3; settle();
        check("rr_c1_stall", stall, 1);
        nxt();
        rst = 1; settle();
        check("rr_c2_issue", issue, 0);
        nxt();
        rst = 0; settle();
        check("rr_c3_pend", pend_mask, 8'h00);
        check("rr_c3_stall_cnt", stall_cycles, 0);
        check("rr_c3_issue", issue, 1);
        nxt(); idle(); settle();
        check("rr_inst_out", inst_out, 16'h2013);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
